ped_signal_ctrl: RTL and testbench
==================================

# ped_signal_ctrl

Pedestrian signal controller sitting directly downstream of the vehicle traffic-light controller. It consumes the vehicle green/yellow/red outputs and the 5-second period tick, latches pedestrian push-button requests, and grants a WALK phase only within a vehicle red phase. WALK is followed by a timed, flashing clearance phase with a countdown display. A sticky fault state forces steady DON'T WALK on any unsafe vehicle-light condition.

## Interface
- WALK_T, 10: WALK duration in ticks, 1..63
- CLEAR_T, 5: clearance (flashing) duration in ticks, 1..63
- FLASH_DIV, 25000: clk cycles per flash half-period, 1..65535
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  one-clk pulse per 5 s period, aligned with vehicle light updates
- veh_green  in  1  vehicle green, synchronous to clk
- veh_yellow  in  1  vehicle yellow, synchronous to clk
- veh_red  in  1  vehicle red, synchronous to clk
- ped_btn  in  1  raw push button, asynchronous, active-high
- walk  out  1  WALK lamp
- dont_walk  out  1  DON'T WALK lamp; steady or flashing
- countdown  out  6  remaining clearance ticks; 0 outside CLEAR
- req_pending  out  1  latched, not-yet-served request
- fault  out  1  sticky unsafe-condition flag

## Operation
- Reset values: walk=0, dont_walk=1, countdown=0, req_pending=0, fault=0, state=IDLE.
- ped_btn passes through a 2-flop synchronizer and rising-edge detector; each edge sets req_pending.
- red_start = veh_red & ~red_q, where red_q is veh_red registered.
- States:
  - IDLE: walk=0, dont_walk=1 steady.
    - red_start with req_pending (or a button edge in the same cycle) -> WALK: load counter=WALK_T, clear req_pending.
    - A request arriving mid-red waits for the next red_start. No partial WALK.
  - WALK: walk=1, dont_walk=0.
    - Counter decrements on tick.
    - tick with counter==1 -> CLEAR: load counter=CLEAR_T.
  - CLEAR: walk=0, dont_walk flashes, countdown=counter.
    - Flash starts on; toggles every FLASH_DIV clk cycles; the flash divider is reset on CLEAR entry.
    - Counter decrements on tick.
    - tick with counter==1 -> IDLE.
  - FAULT: walk=0, dont_walk=1 steady, fault=1. Left only by reset.
- Button edges during WALK are ignored. Edges during CLEAR or IDLE set req_pending.
- Fault entry, from any state, takes priority over all other transitions:
  - {veh_green, veh_yellow, veh_red} is not one-hot, or
  - veh_red=0 while in WALK or CLEAR.
- Counter arithmetic: 6-bit unsigned, never decrements below 1 within a state. Out-of-range parameters are flagged by an elaboration-time check.

## Timing
- All outputs are registered. Each changes on the clk edge after the cause is sampled.
- ped_btn rising edge to req_pending=1: 3 clk edges (2 sync + edge register).
- red_start to walk=1: 1 clk edge.
- WALK lasts exactly WALK_T tick pulses after entry. A tick in the entry cycle itself does not count.
- CLEAR lasts exactly CLEAR_T ticks under the same rule. countdown shows CLEAR_T, CLEAR_T-1, …, 1, then 0 in IDLE.
- Fault to dont_walk=1 steady and walk=0: 1 clk edge, including mid-WALK and mid-flash.
- Reset asserted mid-phase: all outputs return to reset values immediately (asynchronously). The pending request is lost.
- WALK_T + CLEAR_T must not exceed the vehicle red duration in ticks. Otherwise the red drop causes FAULT; this is a system-level constraint.

## Structure
- Shared package ped_pkg:
  - state enum IDLE/WALK/CLEAR/FAULT
  - default timing constants
  - COUNT_W=6
- Sub-module sync_edge: 2-flop synchronizer plus registered rising-edge pulse. Reset to 0. Reusable for other async inputs.
- Main module contains:
  - the FSM
  - the tick counter
  - the flash divider
  - the request latch
  - the fault detect

## Test plan
- Press ped_btn during green, then vehicle sequence green->yellow->red.
  - walk=1 one clk after red_start.
  - walk lasts 10 ticks, then 5 ticks of flashing dont_walk with countdown 5..1.
  - req_pending=0 from WALK entry.
- No button press through a full vehicle cycle: walk stays 0, dont_walk steady 1, countdown 0.
- Button press 3 ticks into red: no WALK in that red. WALK starts at the next red_start.
- Force veh_red=0 with veh_green=1 at tick 4 of WALK: one clk later walk=0, dont_walk=1 steady, fault=1. fault persists until reset.
- Drive veh_green=1 and veh_red=1 simultaneously while in IDLE: FAULT within 1 clk.
- Assert reset mid-CLEAR with req_pending=1: all outputs return to reset values immediately. After release, no WALK until a new press.

Source files
------------

// File: rtl/ped_pkg.sv
// ped_pkg: shared types and default timing for the pedestrian signal controller.
//   ped_state_e  - controller phase (IDLE/WALK/CLEAR/FAULT)
//   COUNT_W      - width of the tick counter and countdown display
//   DIV_W        - width of the flash half-period divider
//   *_DEF        - default WALK/CLEAR durations (ticks) and flash divider (clk cycles)
package ped_pkg;
  localparam int COUNT_W       = 6;
  localparam int DIV_W         = 16;
  localparam int WALK_T_DEF    = 10;
  localparam int CLEAR_T_DEF   = 5;
  localparam int FLASH_DIV_DEF = 25000;

  typedef enum logic [1:0] {IDLE, WALK, CLEAR, FAULT} ped_state_e;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer for an asynchronous level input plus a
// registered rising-edge pulse.
//   clk, reset - clock, async active-high reset (all flops clear to 0)
//   din        - asynchronous input level
//   rise       - one-clk pulse, asserted the cycle the synchronized level goes high
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic s1, s2;

  // rise is registered from s1 vs s2, so it lines up with s2 going high:
  // an input edge reaches rise after two clk edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= s1 & ~s2;
    end
  end
endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian WALK / DON'T WALK controller slaved to the
// vehicle light outputs. Grants WALK at the start of a vehicle red when a
// request is latched, follows it with a flashing timed clearance, and locks
// into a steady DON'T WALK fault on any unsafe vehicle-light combination.
//   clk, reset   - clock, async active-high reset
//   tick         - one-clk period pulse, aligned with vehicle light updates
//   veh_green/yellow/red - vehicle lights (synchronous)
//   ped_btn      - raw asynchronous push button
//   walk, dont_walk      - lamp drives (dont_walk flashes during CLEAR)
//   countdown    - remaining clearance ticks, 0 outside CLEAR
//   req_pending  - latched, not-yet-served request
//   fault        - sticky unsafe-condition flag (cleared only by reset)
module ped_signal_ctrl import ped_pkg::*; #(
  parameter int WALK_T    = WALK_T_DEF,
  parameter int CLEAR_T   = CLEAR_T_DEF,
  parameter int FLASH_DIV = FLASH_DIV_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               veh_green,
  input  logic               veh_yellow,
  input  logic               veh_red,
  input  logic               ped_btn,
  output logic               walk,
  output logic               dont_walk,
  output logic [COUNT_W-1:0] countdown,
  output logic               req_pending,
  output logic               fault
);
  if (WALK_T < 1 || WALK_T > (2**COUNT_W - 1)) begin : g_chk_walk
    $error("WALK_T out of range 1..63");
  end
  if (CLEAR_T < 1 || CLEAR_T > (2**COUNT_W - 1)) begin : g_chk_clear
    $error("CLEAR_T out of range 1..63");
  end
  if (FLASH_DIV < 1 || FLASH_DIV > (2**DIV_W - 1)) begin : g_chk_flash
    $error("FLASH_DIV out of range 1..65535");
  end

  localparam logic [COUNT_W-1:0] WALK_LD    = COUNT_W'(WALK_T);
  localparam logic [COUNT_W-1:0] CLEAR_LD   = COUNT_W'(CLEAR_T);
  localparam logic [COUNT_W-1:0] CNT_ONE    = COUNT_W'(1);
  localparam logic [DIV_W-1:0]   FLASH_LAST = DIV_W'(FLASH_DIV - 1);

  ped_state_e         state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               flash_q, flash_d;
  logic               req_q, req_d;
  logic               red_q, red_start, btn_rise, unsafe;

  sync_edge u_btn (
    .clk   (clk),
    .reset (reset),
    .din   (ped_btn),
    .rise  (btn_rise)
  );

  assign red_start = veh_red & ~red_q;
  assign unsafe    = ~$onehot({veh_green, veh_yellow, veh_red}) |
                     (~veh_red & ((state_q == WALK) | (state_q == CLEAR)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    flash_d = flash_q;
    req_d   = req_q;
    case (state_q)
      IDLE:
        if (red_start && (req_q || btn_rise)) begin
          state_d = WALK;
          cnt_d   = WALK_LD;
        end
      WALK:
        if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = CLEAR;
            cnt_d   = CLEAR_LD;
          end else cnt_d = cnt_q - CNT_ONE;
        end
      CLEAR:
        if (tick) begin
          if (cnt_q == CNT_ONE) state_d = IDLE;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
      default: ;
    endcase
    // Fault beats every other transition, including a WALK grant this cycle.
    if (unsafe) state_d = FAULT;

    // A granted request is consumed; edges during WALK/FAULT are dropped.
    if (state_q == IDLE && state_d == WALK) req_d = 1'b0;
    else if (btn_rise && (state_q == IDLE || state_q == CLEAR)) req_d = 1'b1;

    // Flash phase restarts "on" with a cleared divider at each CLEAR entry.
    if (state_d == CLEAR && state_q != CLEAR) begin
      div_d   = '0;
      flash_d = 1'b1;
    end else if (state_q == CLEAR) begin
      if (div_q == FLASH_LAST) begin
        div_d   = '0;
        flash_d = ~flash_q;
      end else div_d = div_q + DIV_W'(1);
    end
  end

  // Outputs are registered from next-state values so each follows its cause
  // by exactly one clk edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      flash_q   <= 1'b0;
      req_q     <= 1'b0;
      red_q     <= 1'b0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      countdown <= '0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      flash_q   <= flash_d;
      req_q     <= req_d;
      red_q     <= veh_red;
      walk      <= (state_d == WALK);
      dont_walk <= (state_d == WALK)  ? 1'b0 :
                   (state_d == CLEAR) ? flash_d : 1'b1;
      countdown <= (state_d == CLEAR) ? cnt_d : '0;
      fault     <= (state_d == FAULT);
    end
  end

  assign req_pending = req_q;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb_ped_signal_ctrl: directed + randomized stimulus for ped_signal_ctrl,
// checked every clk against a phase/tick-level reference model.
module tb_ped_signal_ctrl;
  localparam int WT = 10;  // WALK ticks
  localparam int CT = 5;   // CLEAR ticks
  localparam int FD = 3;   // flash half-period in clk cycles
  localparam int TP = 6;   // clk cycles per tick period

  localparam int PH_IDLE = 0, PH_WALK = 1, PH_CLR = 2, PH_FLT = 3;

  logic       clk = 1'b0;
  logic       reset, tick, veh_green, veh_yellow, veh_red, ped_btn;
  logic       walk, dont_walk, req_pending, fault;
  logic [5:0] countdown;

  int checks = 0;
  int failures = 0;

  // reference model state
  int     m_phase, m_left, m_clr;
  bit     m_pend, m_red_prev;
  bit [3:0] m_hist;  // [0] = button sampled this edge, [3] = three edges ago
  bit     btn_lvl;

  ped_signal_ctrl #(.WALK_T(WT), .CLEAR_T(CT), .FLASH_DIV(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .veh_green   (veh_green),
    .veh_yellow  (veh_yellow),
    .veh_red     (veh_red),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .req_pending (req_pending),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_left = 0; m_clr = 0;
    m_pend = 1'b0; m_red_prev = 1'b0; m_hist = '0;
  endtask

  // One clk edge of the specified behaviour, given the inputs sampled there.
  task automatic model_step(input bit t, input bit g, input bit y, input bit r, input bit b);
    bit ev, rs, unsafe, to_walk;
    int prev;
    m_hist = {m_hist[2:0], b};
    ev = m_hist[2] & ~m_hist[3];          // press reaches the FSM two edges late
    rs = r & ~m_red_prev;
    m_red_prev = r;
    unsafe = ((int'(g) + int'(y) + int'(r)) != 1) ||
             (!r && (m_phase == PH_WALK || m_phase == PH_CLR));
    prev = m_phase;
    to_walk = 1'b0;
    if (prev != PH_FLT && unsafe) m_phase = PH_FLT;
    else begin
      case (prev)
        PH_IDLE: if (rs && (m_pend || ev)) begin
          m_phase = PH_WALK; m_left = WT; to_walk = 1'b1;
        end
        PH_WALK: if (t) begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_CLR; m_left = CT; m_clr = 0; end
        end
        PH_CLR: begin
          m_clr++;
          if (t) begin
            m_left--;
            if (m_left == 0) m_phase = PH_IDLE;
          end
        end
        default: ;
      endcase
    end
    if (to_walk) m_pend = 1'b0;
    else if (ev && (prev == PH_IDLE || prev == PH_CLR)) m_pend = 1'b1;
  endtask

  task automatic check_all();
    int e_walk, e_dw, e_cd, e_flt;
    e_walk = (m_phase == PH_WALK);
    e_flt  = (m_phase == PH_FLT);
    e_cd   = (m_phase == PH_CLR) ? m_left : 0;
    if (m_phase == PH_WALK)     e_dw = 0;
    else if (m_phase == PH_CLR) e_dw = ((m_clr / FD) % 2 == 0);
    else                        e_dw = 1;
    chk("walk",        8'(walk),        8'(e_walk));
    chk("dont_walk",   8'(dont_walk),   8'(e_dw));
    chk("countdown",   8'(countdown),   8'(e_cd));
    chk("req_pending", 8'(req_pending), 8'(m_pend));
    chk("fault",       8'(fault),       8'(e_flt));
  endtask

  // Drive inputs just after an edge, step the model at the next edge, check #1 later.
  task automatic cycle(input bit t, input bit g, input bit y, input bit r, input bit b);
    tick = t; veh_green = g; veh_yellow = y; veh_red = r; ped_btn = b;
    @(posedge clk);
    model_step(t, g, y, r, b);
    #1 check_all();
  endtask

  // n tick periods with fixed lights; lights change in the tick cycle.
  task automatic run_ticks(input int n, input bit g, input bit y, input bit r,
                           input int press_at, input bit rnd);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < TP; c++) begin
        if (rnd) begin
          if ($urandom_range(0, 24) == 0) btn_lvl = ~btn_lvl;
        end else btn_lvl = (k == press_at) && (c >= 1) && (c <= 4);
        cycle(c == 0, g, y, r, btn_lvl);
      end
    end
  endtask

  task automatic veh_cycle(input int press_green, input int press_red, input bit rnd);
    run_ticks(4, 1'b1, 1'b0, 1'b0, press_green, rnd);
    run_ticks(1, 1'b0, 1'b1, 1'b0, -1, rnd);
    run_ticks(17, 1'b0, 1'b0, 1'b1, press_red, rnd);
  endtask

  // Asynchronous reset between edges; outputs must clear before any edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    ped_btn = 1'b0;
    btn_lvl = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; veh_green = 1'b1; veh_yellow = 1'b0;
    veh_red = 1'b0; ped_btn = 1'b0; btn_lvl = 1'b0;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // press in green, full WALK/CLEAR in the following red
    veh_cycle(1, -1, 1'b0);
    // no request: nothing happens
    veh_cycle(-1, -1, 1'b0);
    // press 3 ticks into red: served only at the next red
    veh_cycle(-1, 3, 1'b0);
    chk("pend_held_to_next_red", 8'(req_pending), 8'(1));
    veh_cycle(-1, -1, 1'b0);
    // random presses over several vehicle cycles
    repeat (4) veh_cycle(-1, -1, 1'b1);

    // reset mid-CLEAR with a pending request
    run_ticks(4, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    run_ticks(1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    run_ticks(12, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    run_ticks(1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("pend_in_clear", 8'(req_pending), 8'(1));
    do_reset();
    run_ticks(4, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    veh_cycle(-1, -1, 1'b0);

    // green with red dropped at the 4th tick of WALK
    run_ticks(4, 1'b1, 1'b0, 1'b0, 1, 1'b0);
    run_ticks(1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    run_ticks(4, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    run_ticks(3, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    chk("fault_mid_walk", 8'(fault), 8'(1));
    veh_cycle(1, -1, 1'b0);
    chk("fault_sticky", 8'(fault), 8'(1));
    do_reset();

    // green and red together while idle
    run_ticks(1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    run_ticks(2, 1'b1, 1'b0, 1'b1, -1, 1'b0);
    chk("fault_gr_idle", 8'(fault), 8'(1));
    do_reset();
    run_ticks(2, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
